instr_encoder_loader: RTL and testbench

- Writer-side counterpart to the instruction decode path: accepts decoded instruction fields (opcode, func, registers, immediate, target) over a valid/ready handshake.
- Packs the fields into 32-bit MIPS R/I/J words and writes them sequentially into instruction memory starting at a base word address.
- Used by the bench/boot path to load programs that the fetch stage and control unit later consume.

---
 rtl/instr_encoder_loader.sv | 192 +++++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Accepts decoded MIPS instruction fields over a valid/ready handshake, packs them into
//   32-bit R/I/J words and writes them sequentially into instruction memory starting at
//   BASE_ADDR. One word every two cycles; the word is written the cycle after accept.
//
// Parameters
//   ADDR_W     instruction memory word-address width
//   BASE_ADDR  first word address written after start
//   DEPTH      maximum words per load session (<= 2**ADDR_W)
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 opens a load session (only honoured in IDLE)
//   in_valid / in_ready   field bundle handshake; in_ready is high only in LOAD
//   in_last               final instruction of the session
//   in_op .. in_target    decoded instruction fields
//   imem_we/addr/wdata    instruction memory write port
//   busy                  high in LOAD or WRITE
//   done                  one-cycle pulse at end of session
//   count                 words written this session
//   err_overflow          sticky until next start: DEPTH reached without in_last
//   err_bad_op            sticky until next start: unsupported opcode seen
//
// Build option
//   INSTR_ENCODER_OPCHECK_EN  when defined, unsupported opcodes are written as NOP and
//                             flagged on err_bad_op; otherwise err_bad_op is tied 0.

module instr_encoder_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned DEPTH     = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [5:0]        in_op,
    input  logic [5:0]        in_func,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err_overflow,
    output logic              err_bad_op
);

    localparam int unsigned CntW = ADDR_W + 1;
    localparam logic [CntW-1:0]   DepthC = CntW'(DEPTH);
    localparam logic [ADDR_W-1:0] BaseC  = ADDR_W'(BASE_ADDR);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StLoad  = 2'd1;
    localparam logic [1:0] StWrite = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [CntW-1:0]   count_inc;
    logic              ovf_q, ovf_d;
    logic [31:0]       enc_word;
    logic              enc_bad;

    // Field packing by opcode class; fields outside the selected format are dropped.
    always_comb begin
        case (in_op)
            6'd0, 6'd11: enc_word = {in_op, in_rs, in_rt, in_rd, in_shamt, in_func};
            6'd2, 6'd3:  enc_word = {in_op, in_target};
            default:     enc_word = {in_op, in_rs, in_rt, in_imm};
        endcase
        enc_bad = 1'b0;
`ifdef INSTR_ENCODER_OPCHECK_EN
        if (!(in_op inside {6'd0, 6'd1, 6'd2, 6'd3, [6'd8:6'd15], 6'd35, 6'd36, 6'd41, 6'd43,
                            [6'd48:6'd54]})) begin
            enc_bad  = 1'b1;
            enc_word = 32'h0000_0000;
        end
`endif
    end

    assign count_inc = count_q + 1'b1;

`ifdef INSTR_ENCODER_OPCHECK_EN
    logic bad_q, bad_d;
`endif

    always_comb begin
        state_d = state_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        addr_d  = addr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
`ifdef INSTR_ENCODER_OPCHECK_EN
        bad_d   = bad_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    count_d = '0;
                    ovf_d   = 1'b0;
                    addr_d  = BaseC;
`ifdef INSTR_ENCODER_OPCHECK_EN
                    bad_d   = 1'b0;
`endif
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (in_valid) begin
                    wdata_d = enc_word;
                    last_d  = in_last;
`ifdef INSTR_ENCODER_OPCHECK_EN
                    bad_d   = bad_q | enc_bad;
`endif
                    state_d = StWrite;
                end
            end
            StWrite: begin
                count_d = count_inc;
                addr_d  = addr_q + 1'b1;  // wraps modulo 2**ADDR_W
                if (last_q || (count_inc == DepthC)) begin
                    // A DEPTH-th word that also carries last is a clean finish.
                    if (!last_q) begin
                        ovf_d = 1'b1;
                    end
                    state_d = StDone;
                end else begin
                    state_d = StLoad;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            wdata_q <= 32'h0000_0000;
            last_q  <= 1'b0;
            addr_q  <= BaseC;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef INSTR_ENCODER_OPCHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_q <= 1'b0;
        end else begin
            bad_q <= bad_d;
        end
    end
    assign err_bad_op = bad_q;
`else
    assign err_bad_op = 1'b0;
    logic unused_enc_bad;
    assign unused_enc_bad = enc_bad;
`endif

    // Outputs decode straight from the state register so reset drops imem_we at once.
    assign in_ready     = (state_q == StLoad);
    assign imem_we      = (state_q == StWrite);
    assign busy         = (state_q == StLoad) || (state_q == StWrite);
    assign done         = (state_q == StDone);
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign count        = count_q;
    assign err_overflow = ovf_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned BASE   = 0;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_last = 1'b0;
    logic [5:0]        in_op = '0;
    logic [5:0]        in_func = '0;
    logic [4:0]        in_rs = '0;
    logic [4:0]        in_rt = '0;
    logic [4:0]        in_rd = '0;
    logic [4:0]        in_shamt = '0;
    logic [15:0]       in_imm = '0;
    logic [25:0]       in_target = '0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   count;
    logic              err_overflow;
    logic              err_bad_op;

    int vectors = 0;
    int errors  = 0;

    logic [ADDR_W-1:0] wa[$];
    logic [31:0]       wd[$];

    instr_encoder_loader #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE),
        .DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_last     (in_last),
        .in_op       (in_op),
        .in_func     (in_func),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_rd       (in_rd),
        .in_shamt    (in_shamt),
        .in_imm      (in_imm),
        .in_target   (in_target),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .busy        (busy),
        .done        (done),
        .count       (count),
        .err_overflow(err_overflow),
        .err_bad_op  (err_bad_op)
    );

    always #5 clk = ~clk;

    // Log every memory write, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    task automatic do_start;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send(input logic [5:0] op, input logic [5:0] func, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] shamt,
                        input logic [15:0] imm, input logic [25:0] tgt, input logic last,
                        input int limit, output bit ok, output int waits);
        in_op = op; in_func = func; in_rs = rs; in_rt = rt; in_rd = rd;
        in_shamt = shamt; in_imm = imm; in_target = tgt; in_last = last;
        in_valid = 1'b1;
        ok = 1'b0;
        waits = 0;
        while (waits < limit && !in_ready) begin
            @(posedge clk);
            #1;
            waits++;
        end
        if (in_ready) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok, output int waits);
        ok = 1'b0;
        waits = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            waits++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        vectors++;
        if ({in_ready, imem_we, busy, done, err_overflow, err_bad_op} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, expected 000000",
                     {in_ready, imem_we, busy, done, err_overflow, err_bad_op});
        end
        vectors++;
        if (imem_addr !== ADDR_W'(BASE) || imem_wdata !== 32'h0 || count !== '0) begin
            errors++;
            $display("FAIL reset_data: got addr %h wdata %h count %0d, expected %h 0 0",
                     imem_addr, imem_wdata, count, ADDR_W'(BASE));
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (in_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_ready cycle %0d: got ready %b busy %b, expected 0 0",
                         i, in_ready, busy);
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (wa.size() !== 0) begin
            errors++;
            $display("FAIL idle_writes: got %0d writes, expected 0", wa.size());
        end
    endtask

    task automatic test_single_r;
        bit ok;
        int w;
        wa.delete(); wd.delete();
        do_start;
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_load: got ready %b busy %b, expected 1 1", in_ready, busy);
        end
        send(6'd0, 6'd32, 5'd1, 5'd2, 5'd3, 5'd0, 16'hBEEF, 26'h3FF_FFFF, 1'b1, 20, ok, w);
        vectors++;
        if (ok !== 1'b1 || w !== 0) begin
            errors++;
            $display("FAIL add_accept: got ok %b waits %0d, expected 1 0", ok, w);
        end
        vectors++;
        if (imem_we !== 1'b1 || imem_addr !== 8'd0 || imem_wdata !== 32'h0022_1820) begin
            errors++;
            $display("FAIL add_write: got we %b addr %h data %h, expected 1 00 00221820",
                     imem_we, imem_addr, imem_wdata);
        end
        wait_done(ok, w);
        vectors++;
        if (ok !== 1'b1 || w !== 1 || count !== 9'd1) begin
            errors++;
            $display("FAIL add_done: got ok %b waits %0d count %0d, expected 1 1 1", ok, w, count);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || count !== 9'd1 || wa.size() !== 1) begin
            errors++;
            $display("FAIL add_after: got done %b busy %b count %0d writes %0d, expected 0 0 1 1",
                     done, busy, count, wa.size());
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int w;
        logic [31:0] exp_d [0:2];
        exp_d[0] = 32'h8C85_0010;
        exp_d[1] = 32'h0800_0100;
        exp_d[2] = 32'h00E8_4880;
        wa.delete(); wd.delete();
        do_start;
        send(6'd35, 6'h3F, 5'd4, 5'd5, 5'd31, 5'd31, 16'h0010, 26'h2AA_AAAA, 1'b0, 20, ok, w);
        vectors++;
        if (ok !== 1'b1 || w !== 0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_lw: got ok %b waits %0d ready %b, expected 1 0 0", ok, w, in_ready);
        end
        send(6'd2, 6'h15, 5'd9, 5'd9, 5'd9, 5'd9, 16'hFFFF, 26'h000_0100, 1'b0, 20, ok, w);
        vectors++;
        if (ok !== 1'b1 || w !== 1) begin
            errors++;
            $display("FAIL b2b_j: got ok %b waits %0d, expected 1 1", ok, w);
        end
        send(6'd0, 6'd0, 5'd7, 5'd8, 5'd9, 5'd2, 16'h5555, 26'h155_5555, 1'b1, 20, ok, w);
        vectors++;
        if (ok !== 1'b1 || w !== 1) begin
            errors++;
            $display("FAIL b2b_r: got ok %b waits %0d, expected 1 1", ok, w);
        end
        wait_done(ok, w);
        vectors++;
        if (ok !== 1'b1 || count !== 9'd3) begin
            errors++;
            $display("FAIL b2b_done: got ok %b count %0d, expected 1 3", ok, count);
        end
        vectors++;
        if (wa.size() !== 3) begin
            errors++;
            $display("FAIL b2b_nwrites: got %0d, expected 3", wa.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (wa[i] !== ADDR_W'(i) || wd[i] !== exp_d[i]) begin
                    errors++;
                    $display("FAIL b2b_word %0d: got addr %h data %h, expected %h %h",
                             i, wa[i], wd[i], ADDR_W'(i), exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_overflow;
        bit ok;
        int w;
        wa.delete(); wd.delete();
        do_start;
        for (int i = 0; i < 4; i++) begin
            send(6'd8, 6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 16'(i), 26'd0, 1'b0, 20, ok, w);
            vectors++;
            if (ok !== 1'b1 || imem_wdata !== (32'h2022_0000 | 32'(i))) begin
                errors++;
                $display("FAIL ovf_word %0d: got ok %b data %h, expected 1 %h",
                         i, ok, imem_wdata, 32'h2022_0000 | 32'(i));
            end
        end
        wait_done(ok, w);
        vectors++;
        if (ok !== 1'b1 || w !== 1 || err_overflow !== 1'b1 || count !== 9'd4) begin
            errors++;
            $display("FAIL ovf_done: got ok %b waits %0d ovf %b count %0d, expected 1 1 1 4",
                     ok, w, err_overflow, count);
        end
        send(6'd8, 6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 16'd4, 26'd0, 1'b0, 10, ok, w);
        vectors++;
        if (ok !== 1'b0 || wa.size() !== 4) begin
            errors++;
            $display("FAIL ovf_fifth: got accepted %b writes %0d, expected 0 4", ok, wa.size());
        end
        vectors++;
        if (err_overflow !== 1'b1 || count !== 9'd4) begin
            errors++;
            $display("FAIL ovf_hold: got ovf %b count %0d, expected 1 4", err_overflow, count);
        end
    endtask

    task automatic test_depth_last;
        bit ok;
        int w;
        do_start;
        vectors++;
        if (err_overflow !== 1'b0 || count !== 9'd0) begin
            errors++;
            $display("FAIL restart_clear: got ovf %b count %0d, expected 0 0", err_overflow, count);
        end
        for (int i = 0; i < 4; i++) begin
            send(6'd13, 6'd0, 5'd3, 5'd3, 5'd0, 5'd0, 16'hF0F0, 26'd0, (i == 3), 20, ok, w);
        end
        wait_done(ok, w);
        vectors++;
        if (ok !== 1'b1 || err_overflow !== 1'b0 || count !== 9'd4) begin
            errors++;
            $display("FAIL depth_last: got ok %b ovf %b count %0d, expected 1 0 4",
                     ok, err_overflow, count);
        end
    endtask

    task automatic test_formats;
        bit ok;
        int w;
        do_start;
        send(6'd3, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FF_FFFF, 1'b0, 20, ok, w);
        vectors++;
        if (imem_wdata !== 32'h0FFF_FFFF) begin
            errors++;
            $display("FAIL fmt_jal: got %h, expected 0fffffff", imem_wdata);
        end
        send(6'd11, 6'd5, 5'd1, 5'd2, 5'd3, 5'd4, 16'hFFFF, 26'h3FF_FFFF, 1'b0, 20, ok, w);
        vectors++;
        if (imem_wdata !== 32'h2C22_1905) begin
            errors++;
            $display("FAIL fmt_r11: got %h, expected 2c221905", imem_wdata);
        end
        send(6'd43, 6'h3F, 5'd29, 5'd31, 5'd31, 5'd31, 16'hFFFC, 26'h3FF_FFFF, 1'b1, 20, ok, w);
        vectors++;
        if (imem_wdata !== 32'hAFBF_FFFC || imem_addr !== 8'd2) begin
            errors++;
            $display("FAIL fmt_sw: got addr %h data %h, expected 02 afbffffc",
                     imem_addr, imem_wdata);
        end
        wait_done(ok, w);
    endtask

    task automatic test_reset_mid_write;
        bit ok;
        int w;
        do_start;
        send(6'd9, 6'd0, 5'd1, 5'd1, 5'd0, 5'd0, 16'h0001, 26'd0, 1'b0, 20, ok, w);
        send(6'd9, 6'd0, 5'd1, 5'd1, 5'd0, 5'd0, 16'h0002, 26'd0, 1'b0, 20, ok, w);
        vectors++;
        if (imem_we !== 1'b1 || count !== 9'd1) begin
            errors++;
            $display("FAIL rst_pre: got we %b count %0d, expected 1 1", imem_we, count);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (imem_we !== 1'b0 || count !== 9'd0 || busy !== 1'b0 || imem_addr !== 8'd0) begin
            errors++;
            $display("FAIL rst_async: got we %b count %0d busy %b addr %h, expected 0 0 0 00",
                     imem_we, count, busy, imem_addr);
        end
        #1 rst_n = 1'b1;
        wa.delete(); wd.delete();
        do_start;
        send(6'd15, 6'd0, 5'd0, 5'd6, 5'd0, 5'd0, 16'h1234, 26'd0, 1'b1, 20, ok, w);
        vectors++;
        if (imem_addr !== 8'd0 || imem_wdata !== 32'h3C06_1234) begin
            errors++;
            $display("FAIL rst_reload: got addr %h data %h, expected 00 3c061234",
                     imem_addr, imem_wdata);
        end
        wait_done(ok, w);
        vectors++;
        if (ok !== 1'b1 || count !== 9'd1) begin
            errors++;
            $display("FAIL rst_reload_done: got ok %b count %0d, expected 1 1", ok, count);
        end
    endtask

    task automatic test_bad_op;
        bit ok;
        int w;
        logic [31:0] exp_word;
        logic        exp_bad;
`ifdef INSTR_ENCODER_OPCHECK_EN
        exp_word = 32'h0000_0000;
        exp_bad  = 1'b1;
`else
        exp_word = 32'hFC64_1234;
        exp_bad  = 1'b0;
`endif
        do_start;
        send(6'd63, 6'd7, 5'd3, 5'd4, 5'd5, 5'd6, 16'h1234, 26'h155_5555, 1'b1, 20, ok, w);
        vectors++;
        if (imem_wdata !== exp_word) begin
            errors++;
            $display("FAIL badop_word: got %h, expected %h", imem_wdata, exp_word);
        end
        wait_done(ok, w);
        vectors++;
        if (ok !== 1'b1 || err_bad_op !== exp_bad || count !== 9'd1) begin
            errors++;
            $display("FAIL badop_flag: got ok %b bad %b count %0d, expected 1 %b 1",
                     ok, err_bad_op, count, exp_bad);
        end
        do_start;
        vectors++;
        if (err_bad_op !== 1'b0 || count !== 9'd0) begin
            errors++;
            $display("FAIL badop_clear: got bad %b count %0d, expected 0 0", err_bad_op, count);
        end
    endtask

    initial begin
        test_reset;
        test_single_r;
        test_back_to_back;
        test_overflow;
        test_depth_last;
        test_formats;
        test_reset_mid_write;
        test_bad_op;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
